// File: rtl/csi2_packet_parser.sv
// rtl/csi2_packet_parser.sv - CSI-2 packet layer: header parse, short-packet strobes, long-packet payload filter
//
// Purpose: takes merged lane bytes (pLanes per beat, lane0 earliest) from the clock-crossing FIFO,
// collects the 4-byte packet header, decodes FS/FE/LS/LE short packets into strobes and forwards
// long-packet payload (accepted VC and DT only) as keep/last-tagged beats over valid/ready.
//
// Ports:
//   iSCLK, inSRST                 clock, asynchronous active-low reset
//   iWd, iWvd, iSop, oRe          input beat, valid, start-of-packet, beat accepted (FIFO read)
//   oPixel, oKeep, oLast, oValid  payload beat out, byte keep, last beat, valid
//   iRdy                          downstream ready
//   oDatatype, oVc, oWordCnt      header fields of the last accepted long packet
//   oFs, oFe, oLs, oLe, oFrameNum short-packet strobes and their WC field
//   oPktErr                       one-cycle pulse on abort (or header ECC error)
//
// Configuration macro: CSI2_ECC_CHECK_EN enables header ECC checking in CHECK.
module csi2_packet_parser #(
   parameter int         pLanes  = 2,
   parameter logic [3:0] pVcMask = 4'hF,
   parameter logic [5:0] pDtMin  = 6'h18
) (
   input  logic                iSCLK,
   input  logic                inSRST,
   input  logic [8*pLanes-1:0] iWd,
   input  logic                iWvd,
   input  logic                iSop,
   output logic                oRe,
   output logic [8*pLanes-1:0] oPixel,
   output logic [pLanes-1:0]   oKeep,
   output logic                oLast,
   output logic                oValid,
   input  logic                iRdy,
   output logic [5:0]          oDatatype,
   output logic [1:0]          oVc,
   output logic [15:0]         oWordCnt,
   output logic                oFs,
   output logic                oFe,
   output logic                oLs,
   output logic                oLe,
   output logic [15:0]         oFrameNum,
   output logic                oPktErr
);

   // Without ECC checking the ECC byte is never stored.
`ifdef CSI2_ECC_CHECK_EN
   localparam int HB = 4;
`else
   localparam int HB = 3;
`endif
   localparam logic [2:0]  LANES3  = 3'(pLanes);
   localparam logic [15:0] LANES16 = 16'(pLanes);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_CHECK, S_PAYLOAD, S_DROP} state_t;

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [8*HB-1:0]     hdr_q, hdr_d;
   logic [15:0]         rem_q, rem_d;
   logic [8*pLanes-1:0] pixel_q, pixel_d;
   logic [pLanes-1:0]   keep_q, keep_d;
   logic                last_q, last_d, valid_q, valid_d;
   logic [5:0]          dt_q, dt_d;
   logic [1:0]          vc_q, vc_d;
   logic [15:0]         wc_q, wc_d, frame_q, frame_d;
   logic                fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d, err_q, err_d;

   logic [5:0]          h_dt;
   logic [1:0]          h_vc;
   logic [15:0]         h_wc;
   logic                ecc_bad;
   logic                rem_last;
   logic [2:0]          take;
   logic [pLanes-1:0]   keep_n;
   logic                hdr_start, hdr_cont;
   logic [2:0]          hdr_base;

   assign h_dt = hdr_q[5:0];
   assign h_vc = hdr_q[7:6];
   assign h_wc = hdr_q[23:8];

`ifdef CSI2_ECC_CHECK_EN
   // Each row selects the header bits covered by one Hamming parity bit.
   localparam logic [23:0] ECC_MASK [6] = '{24'hF12CB7, 24'hF2555B, 24'h749A6D,
                                            24'hB8E38E, 24'hDF03F0, 24'hEFFC00};
   logic [5:0] ecc_calc;
   logic       unused_ecc_hi;
   always_comb begin
      ecc_calc = '0;
      for (int k = 0; k < 6; k++) ecc_calc[k] = ^(hdr_q[23:0] & ECC_MASK[k]);
   end
   assign ecc_bad       = (ecc_calc != hdr_q[29:24]);
   assign unused_ecc_hi = ^hdr_q[31:30];
`else
   assign ecc_bad = 1'b0;
`endif

   // Downstream backpressure only gates consumption while forwarding payload.
   assign oRe = inSRST & iWvd & (state_q != S_CHECK) &
                ((state_q != S_PAYLOAD) | ~valid_q | iRdy);

   assign rem_last = (rem_q <= LANES16);
   assign take     = rem_last ? rem_q[2:0] : LANES3;
   always_comb begin
      keep_n = '0;
      for (int i = 0; i < pLanes; i++) keep_n[i] = (i < int'(take));
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hdr_d     = hdr_q;
      rem_d     = rem_q;
      pixel_d   = pixel_q;
      keep_d    = keep_q;
      last_d    = last_q;
      valid_d   = valid_q;
      dt_d      = dt_q;
      vc_d      = vc_q;
      wc_d      = wc_q;
      frame_d   = frame_q;
      fs_d      = 1'b0;
      fe_d      = 1'b0;
      ls_d      = 1'b0;
      le_d      = 1'b0;
      err_d     = 1'b0;
      hdr_start = 1'b0;
      hdr_cont  = 1'b0;
      hdr_base  = 3'd0;

      if (valid_q && iRdy) valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Non-SOP beats here are trailing CRC words and are dropped.
            if (oRe && iSop) hdr_start = 1'b1;
         end
         S_HDR: begin
            if (oRe) begin
               if (iSop) begin
                  err_d     = 1'b1;
                  hdr_start = 1'b1;
               end else begin
                  hdr_cont = 1'b1;
               end
            end
         end
         S_CHECK: begin
            state_d = S_IDLE;
            if (ecc_bad) begin
               err_d = 1'b1;
               if (h_dt >= 6'h10 && h_wc != 16'd0) begin
                  rem_d   = h_wc;
                  state_d = S_DROP;
               end
            end else if (h_dt < 6'h10) begin
               fs_d = (h_dt == 6'h00);
               fe_d = (h_dt == 6'h01);
               ls_d = (h_dt == 6'h02);
               le_d = (h_dt == 6'h03);
               if (h_dt < 6'h04) frame_d = h_wc;
            end else begin
               dt_d  = h_dt;
               vc_d  = h_vc;
               wc_d  = h_wc;
               rem_d = h_wc;
               if (h_wc != 16'd0)
                  state_d = (pVcMask[h_vc] && h_dt >= pDtMin) ? S_PAYLOAD : S_DROP;
            end
         end
         S_PAYLOAD, S_DROP: begin
            if (oRe) begin
               if (iSop) begin
                  // Abandon the packet; an already-registered beat still drains.
                  err_d     = 1'b1;
                  hdr_start = 1'b1;
               end else begin
                  rem_d = rem_q - {13'd0, take};
                  if (state_q == S_PAYLOAD) begin
                     pixel_d = iWd;
                     keep_d  = keep_n;
                     last_d  = rem_last;
                     valid_d = 1'b1;
                  end
                  if (rem_last) state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Header bytes land at byte offset hdr_base onward; the SOP beat always starts at 0.
      if (hdr_start || hdr_cont) begin
         hdr_base = hdr_start ? 3'd0 : cnt_q;
         for (int j = 0; j < HB; j++)
            for (int i = 0; i < pLanes; i++)
               if (int'(hdr_base) + i == j) hdr_d[j*8 +: 8] = iWd[i*8 +: 8];
         cnt_d = hdr_base + LANES3;
         if (cnt_d == 3'd4) begin
            state_d = S_CHECK;
            cnt_d   = 3'd0;
         end else begin
            state_d = S_HDR;
         end
      end
   end

   always_ff @(posedge iSCLK or negedge inSRST) begin
      if (!inSRST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hdr_q   <= '0;
         rem_q   <= '0;
         pixel_q <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         dt_q    <= '0;
         vc_q    <= '0;
         wc_q    <= '0;
         frame_q <= '0;
         fs_q    <= 1'b0;
         fe_q    <= 1'b0;
         ls_q    <= 1'b0;
         le_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hdr_q   <= hdr_d;
         rem_q   <= rem_d;
         pixel_q <= pixel_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         dt_q    <= dt_d;
         vc_q    <= vc_d;
         wc_q    <= wc_d;
         frame_q <= frame_d;
         fs_q    <= fs_d;
         fe_q    <= fe_d;
         ls_q    <= ls_d;
         le_q    <= le_d;
         err_q   <= err_d;
      end
   end

   assign oPixel    = pixel_q;
   assign oKeep     = keep_q;
   assign oLast     = last_q;
   assign oValid    = valid_q;
   assign oDatatype = dt_q;
   assign oVc       = vc_q;
   assign oWordCnt  = wc_q;
   assign oFs       = fs_q;
   assign oFe       = fe_q;
   assign oLs       = ls_q;
   assign oLe       = le_q;
   assign oFrameNum = frame_q;
   assign oPktErr   = err_q;

endmodule

// File: tb/tb_csi2_packet_parser.sv
// tb/tb_csi2_packet_parser.sv - scoreboard bench for csi2_packet_parser (2-lane and 4-lane instances)
module tb_csi2_packet_parser;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // 2-lane instance, default filters
   logic [15:0] wd2, px2, fn2, wcn2;
   logic        wvd2, sop2, re2, ol2, ov2, rdy2, fs2, fe2, ls2, le2, err2;
   logic [1:0]  k2, vc2;
   logic [5:0]  dt2;
   // 4-lane instance, only VC0 accepted
   logic [31:0] wd4, px4;
   logic [15:0] fn4, wcn4;
   logic        wvd4, sop4, re4, ol4, ov4, rdy4, fs4, fe4, ls4, le4, err4;
   logic [3:0]  k4;
   logic [1:0]  vc4;
   logic [5:0]  dt4;

   csi2_packet_parser #(.pLanes(2)) u_dut2 (
      .iSCLK(clk), .inSRST(rst_n), .iWd(wd2), .iWvd(wvd2), .iSop(sop2), .oRe(re2),
      .oPixel(px2), .oKeep(k2), .oLast(ol2), .oValid(ov2), .iRdy(rdy2),
      .oDatatype(dt2), .oVc(vc2), .oWordCnt(wcn2), .oFs(fs2), .oFe(fe2), .oLs(ls2), .oLe(le2),
      .oFrameNum(fn2), .oPktErr(err2));

   csi2_packet_parser #(.pLanes(4), .pVcMask(4'h1)) u_dut4 (
      .iSCLK(clk), .inSRST(rst_n), .iWd(wd4), .iWvd(wvd4), .iSop(sop4), .oRe(re4),
      .oPixel(px4), .oKeep(k4), .oLast(ol4), .oValid(ov4), .iRdy(rdy4),
      .oDatatype(dt4), .oVc(vc4), .oWordCnt(wcn4), .oFs(fs4), .oFe(fe4), .oLs(ls4), .oLe(le4),
      .oFrameNum(fn4), .oPktErr(err4));

   beat_t q2[$];
   beat_t q4[$];
   int beats2 = 0, lasts2 = 0, errs2 = 0, beats4 = 0, lasts4 = 0, errs4 = 0, fs_cnt4 = 0;
   bit valid_ever4 = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] bmask(input logic [3:0] k);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[i*8 +: 8] = k[i] ? 8'hFF : 8'h00;
      return m;
   endfunction

   function automatic logic [7:0] ecc_fn(input logic [23:0] d);
      logic [7:0] p;
      p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
      p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
      p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
      p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
      p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
      p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
      p[7:6] = 2'b00;
      return p;
   endfunction

   // Monitors sample 1 time unit before each rising edge.
   logic        stall2 = 0;
   logic [18:0] held2 = '0;
   always begin
      beat_t e;
      @(negedge clk);
      #4;
      if (rst_n) begin
         if (ov2 && rdy2) begin
            check("beat2_expected", 64'(q2.size() != 0), 64'd1);
            if (q2.size() != 0) begin
               e = q2.pop_front();
               check("pix2", {16'h0, px2} & bmask(e.k), e.d);
               check("keep2", {2'b0, k2}, e.k);
               check("last2", ol2, e.l);
            end
            beats2++;
            if (ol2) lasts2++;
         end
         if (stall2) check("hold2", {ol2, k2, px2}, held2);
         stall2 = ov2 && !rdy2;
         held2  = {ol2, k2, px2};
         if (err2) errs2++;
      end
   end

   always begin
      beat_t e;
      @(negedge clk);
      #4;
      if (rst_n) begin
         if (ov4) valid_ever4 = 1;
         if (ov4 && rdy4) begin
            check("beat4_expected", 64'(q4.size() != 0), 64'd1);
            if (q4.size() != 0) begin
               e = q4.pop_front();
               check("pix4", px4 & bmask(e.k), e.d);
               check("keep4", k4, e.k);
               check("last4", ol4, e.l);
            end
            beats4++;
            if (ol4) lasts4++;
         end
         if (err4) errs4++;
         if (fs4) fs_cnt4++;
      end
   end

   // Holds one beat until the DUT accepts it; called and returns at a falling edge.
   task automatic send(input int dut, input logic [31:0] d, input logic sop, input bit tog);
      int t;
      bit acc;
      t = 0;
      acc = 0;
      if (dut == 2) begin wd2 = d[15:0]; wvd2 = 1; sop2 = sop; end
      else          begin wd4 = d;       wvd4 = 1; sop4 = sop; end
      while (!acc && t < 200) begin
         if (tog) rdy2 = ~rdy2;
         #1;
         acc = (dut == 2) ? re2 : re4;
         @(negedge clk);
         t++;
      end
      check("send_accept", 64'(acc), 64'd1);
      wvd2 = 0; sop2 = 0; wvd4 = 0; sop4 = 0;
   endtask

   task automatic send_hdr(input int dut, input logic [7:0] di, input logic [15:0] wc,
                           input bit tog, input logic [23:0] flip);
      logic [7:0]  ecc;
      logic [23:0] h;
      ecc = ecc_fn({wc, di});
      h   = {wc, di} ^ flip;
      if (dut == 2) begin
         send(2, {16'h0, h[15:0]}, 1'b1, tog);
         send(2, {16'h0, ecc, h[23:16]}, 1'b0, tog);
      end else begin
         send(4, {ecc, h}, 1'b1, tog);
      end
   endtask

   task automatic payload(input int dut, input int wc, input bit tog, input int stop_after,
                          input bit fwd);
      int lanes, r, b, n;
      logic [31:0] d;
      beat_t e;
      lanes = (dut == 2) ? 2 : 4;
      r = wc;
      b = 0;
      while (r > 0 && (stop_after < 0 || b < stop_after)) begin
         n = (r < lanes) ? r : lanes;
         d = $urandom;
         if (dut == 2) d[31:16] = 16'h0;
         e.k = 4'((1 << n) - 1);
         e.d = d & bmask(e.k);
         e.l = (r <= lanes);
         if (fwd) begin
            if (dut == 2) q2.push_back(e);
            else          q4.push_back(e);
         end
         send(dut, d, 1'b0, tog);
         r -= n;
         b++;
      end
   endtask

   task automatic pkt(input int dut, input logic [7:0] di, input logic [15:0] wc,
                      input bit tog, input bit fwd);
      send_hdr(dut, di, wc, tog, 24'h0);
      payload(dut, int'(wc), tog, -1, fwd);
      send(dut, 32'hC3C3_C3C3, 1'b0, tog);
   endtask

   task automatic drain(input int dut);
      int t;
      rdy2 = 1;
      rdy4 = 1;
      t = 0;
      while (((dut == 2) ? q2.size() : q4.size()) != 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      check("drain_empty", 64'((dut == 2) ? q2.size() : q4.size()), 64'd0);
   endtask

   initial begin
      int b0, l0, e0;
      rst_n = 0;
      wd2 = '0; wvd2 = 1; sop2 = 0; rdy2 = 1;
      wd4 = '0; wvd4 = 0; sop4 = 0; rdy4 = 1;
      repeat (2) @(negedge clk);
      check("rst_re2", re2, 0);
      check("rst_valid2", ov2, 0);
      check("rst_keep2", k2, 0);
      check("rst_last2", ol2, 0);
      check("rst_err2", err2, 0);
      check("rst_dt2", dt2, 0);
      check("rst_valid4", ov4, 0);
      check("rst_fs4", fs4, 0);
      check("rst_wc4", wcn4, 0);
      check("rst_fn4", fn4, 0);
      wvd2 = 0;
      @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);

      // RAW8, WC=0x0F00 on 2 lanes: 1920 beats
      b0 = beats2; l0 = lasts2;
      pkt(2, 8'h2A, 16'h0F00, 0, 1);
      drain(2);
      check("raw8_beats", beats2 - b0, 1920);
      check("raw8_lasts", lasts2 - l0, 1);
      check("raw8_dt", dt2, 6'h2A);
      check("raw8_wc", wcn2, 16'h0F00);
      check("raw8_err", errs2, 0);

      // FS short packet on 4 lanes
      send_hdr(4, 8'h00, 16'h0005, 0, 24'h0);
      repeat (3) @(negedge clk);
      check("fs_count", fs_cnt4, 1);
      check("fs_frame", fn4, 16'h0005);
      check("fs_no_valid", valid_ever4, 0);
      check("fs_wc_untouched", wcn4, 16'h0000);

      // RAW8 WC=7 on 4 lanes: keep F then 7 with last
      b0 = beats4;
      pkt(4, 8'h2A, 16'd7, 0, 1);
      drain(4);
      check("wc7_beats", beats4 - b0, 2);
      check("wc7_vc", vc4, 2'd0);
      check("wc7_wc", wcn4, 16'd7);

      // VC1 masked on the 4-lane instance: consumed silently
      valid_ever4 = 0;
      pkt(4, 8'h5E, 16'd8, 0, 0);
      send_hdr(4, 8'h00, 16'h0009, 0, 24'h0);
      repeat (3) @(negedge clk);
      check("mask_no_valid", valid_ever4, 0);
      check("mask_no_err", errs4, 0);
      check("mask_then_fs", fs_cnt4, 2);
      check("mask_fs_frame", fn4, 16'h0009);
      check("mask_vc_latched", vc4, 2'd1);

      // Ready toggling during payload
      b0 = beats2;
      pkt(2, 8'h2A, 16'd40, 1, 1);
      drain(2);
      check("tog_beats", beats2 - b0, 20);

      // Long DT below pDtMin: dropped but header latched
      b0 = beats2;
      pkt(2, 8'h12, 16'd4, 0, 0);
      repeat (3) @(negedge clk);
      check("lowdt_beats", beats2 - b0, 0);
      check("lowdt_dt", dt2, 6'h12);

      // WC=0 long packet: no beats
      b0 = beats4;
      send_hdr(4, 8'h2B, 16'd0, 0, 24'h0);
      repeat (3) @(negedge clk);
      check("wc0_beats", beats4 - b0, 0);
      check("wc0_wc", wcn4, 16'd0);
      check("wc0_dt", dt4, 6'h2B);

      // SOP mid-payload after 3 beats: abort then parse new header
      b0 = beats2; l0 = lasts2; e0 = errs2;
      send_hdr(2, 8'h2A, 16'd20, 0, 24'h0);
      payload(2, 20, 0, 3, 1);
      rdy2 = 0;
      pkt(2, 8'h2B, 16'd4, 1, 1);
      drain(2);
      check("abort_err", errs2 - e0, 1);
      check("abort_beats", beats2 - b0, 5);
      check("abort_lasts", lasts2 - l0, 1);
      check("abort_dt", dt2, 6'h2B);
      check("abort_wc", wcn2, 16'd4);

      // WC=0xFFFF on 4 lanes: 16384 beats, final keep 0111 (scoreboard)
      b0 = beats4; l0 = lasts4;
      pkt(4, 8'h2A, 16'hFFFF, 0, 1);
      drain(4);
      check("wcmax_beats", beats4 - b0, 16384);
      check("wcmax_lasts", lasts4 - l0, 1);

`ifdef CSI2_ECC_CHECK_EN
      // One flipped WC bit: ECC error, packet dropped using received WC
      b0 = beats2; e0 = errs2;
      send_hdr(2, 8'h2C, 16'd4, 0, 24'h000100);
      payload(2, 5, 0, -1, 0);
      repeat (3) @(negedge clk);
      check("ecc_err", errs2 - e0, 1);
      check("ecc_beats", beats2 - b0, 0);
      check("ecc_dt_kept", dt2, 6'h2B);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
